// File: rtl/lane_init_ctrl.sv
// Lane initialization sequencer for the USB4 logical layer.
// Walks the lane through sideband detect, lane-parameter exchange, TS1/TS2
// training and CL0, debouncing sbrx and handshaking with the sideband
// transaction engine and the ordered-set generator. All outputs are registered.
module lane_init_ctrl #(
   parameter int T_CONNECT    = 25,
   parameter int T_DISCONNECT = 14,
   parameter int T_TIMEOUT    = 1000,
   parameter int TS_COUNT     = 16
) (
   input  logic       SystemClock,
   input  logic       SystemReset,
   input  logic       enable,
   input  logic       sbrx,
   output logic       sbtx,
   output logic       lp_req,
   input  logic       lp_done,
   input  logic       lp_err,
   output logic       ts_en,
   output logic [1:0] ts_type,
   input  logic       ts1_rcvd,
   input  logic       ts2_rcvd,
   output logic       cl0,
   output logic       disconnect,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      DISABLED    = 3'd0,
      DETECT      = 3'd1,
      LANE_PARAMS = 3'd2,
      TRAIN_TS1   = 3'd3,
      TRAIN_TS2   = 3'd4,
      LANE_CL0    = 3'd5
   } laneState_t;

   localparam int HI_W = $clog2(T_CONNECT + 1);
   localparam int LO_W = $clog2(T_DISCONNECT + 1);
   localparam int TO_W = $clog2(T_TIMEOUT);
   localparam int TS_W = $clog2(TS_COUNT + 1);

   localparam logic [HI_W-1:0] HI_MAX  = HI_W'(T_CONNECT);
   localparam logic [LO_W-1:0] LO_MAX  = LO_W'(T_DISCONNECT);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(T_TIMEOUT - 1);
   localparam logic [TS_W-1:0] TS_LAST = TS_W'(TS_COUNT - 1);
   localparam logic [TS_W-1:0] TS_MAX  = TS_W'(TS_COUNT);

   laneState_t      currentState;
   laneState_t      nextState;
   logic [HI_W-1:0] hiCnt;
   logic [LO_W-1:0] loCnt;
   logic [TO_W-1:0] toCnt;
   logic [TS_W-1:0] tsCnt;

   logic connDet;
   logic discDet;
   logic timeoutHit;
   logic tsPulse;
   logic tsHit;
   logic linkActive;
   logic timedState;
   logic stateChange;
   logic discEvent;

   assign connDet     = (hiCnt >= HI_MAX);
   assign discDet     = (loCnt >= LO_MAX);
   assign timeoutHit  = (toCnt == TO_LAST);
   assign linkActive  = currentState inside {LANE_PARAMS, TRAIN_TS1, TRAIN_TS2, LANE_CL0};
   assign timedState  = currentState inside {LANE_PARAMS, TRAIN_TS1, TRAIN_TS2};
   // TS2 also counts in TRAIN_TS1 because the partner may already be ahead.
   assign tsPulse     = ((currentState == TRAIN_TS1) && (ts1_rcvd || ts2_rcvd)) ||
                        ((currentState == TRAIN_TS2) && ts2_rcvd);
   assign tsHit       = tsPulse && (tsCnt == TS_LAST);
   assign stateChange = (nextState != currentState);
   assign state       = currentState;

   // Debounce sbrx: saturating run-length counters, each cleared by the opposite level.
   always_ff @(posedge SystemClock or negedge SystemReset) begin
      if (!SystemReset) begin
         hiCnt <= '0;
         loCnt <= '0;
      end else if (sbrx) begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         loCnt <= '0;
         if (hiCnt != HI_MAX) hiCnt <= hiCnt + 1'b1;
      end else begin
         hiCnt <= '0;
         if (loCnt != LO_MAX) loCnt <= loCnt + 1'b1;
      end
   end

   // Next-state selection: enable=0 > disconnect > error/timeout > forward progress.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; no latches.
      nextState = currentState;
      discEvent = 1'b0;
      if (!enable) begin
         nextState = DISABLED;
      end else if (linkActive && discDet) begin
         nextState = DETECT;
         discEvent = 1'b1;
      end else if (timedState && timeoutHit) begin
         nextState = DETECT;
      end else begin
         case (currentState)
            DISABLED:    nextState = DETECT;
            DETECT:      if (connDet) nextState = LANE_PARAMS;
            LANE_PARAMS: begin
               if (lp_err)       nextState = DETECT;
               else if (lp_done) nextState = TRAIN_TS1;
            end
            TRAIN_TS1:   if (tsHit) nextState = TRAIN_TS2;
            TRAIN_TS2:   if (tsHit) nextState = LANE_CL0;
            LANE_CL0:    nextState = LANE_CL0;
            default:     nextState = DISABLED;
         endcase
      end
   end

   // State register plus per-state timeout and ordered-set counters, cleared on entry.
   always_ff @(posedge SystemClock or negedge SystemReset) begin
      if (!SystemReset) begin
         currentState <= DISABLED;
         toCnt        <= '0;
         tsCnt        <= '0;
      end else begin
         currentState <= nextState;
         if (stateChange) begin
            toCnt <= '0;
            tsCnt <= '0;
         end else begin
            if (toCnt != TO_LAST)             toCnt <= toCnt + 1'b1;
            if (tsPulse && (tsCnt != TS_MAX)) tsCnt <= tsCnt + 1'b1;
         end
      end
   end

   // Registered outputs, decoded from the state being entered so they align with state.
   always_ff @(posedge SystemClock or negedge SystemReset) begin
      if (!SystemReset) begin
         sbtx       <= 1'b0;
         lp_req     <= 1'b0;
         ts_en      <= 1'b0;
         ts_type    <= 2'd0;
         cl0        <= 1'b0;
         disconnect <= 1'b0;
      end else begin
         sbtx       <= (nextState != DISABLED);
         lp_req     <= (nextState == LANE_PARAMS) && (currentState != LANE_PARAMS);
         ts_en      <= (nextState == TRAIN_TS1) || (nextState == TRAIN_TS2);
         ts_type    <= (nextState == TRAIN_TS1) ? 2'd1 :
                       (nextState == TRAIN_TS2) ? 2'd2 : 2'd0;
         cl0        <= (nextState == LANE_CL0);
         disconnect <= discEvent;
      end
   end

endmodule

// File: tb/tb_lane_init_ctrl.sv
// Self-checking bench for lane_init_ctrl: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// run-length / time-in-state behavioural model.
module tb_lane_init_ctrl;

   localparam int T_CONNECT    = 25;
   localparam int T_DISCONNECT = 14;
   localparam int T_TIMEOUT    = 1000;
   localparam int TS_COUNT     = 16;

   logic       SystemClock = 1'b0;
   logic       SystemReset = 1'b0;
   logic       enable      = 1'b0;
   logic       sbrx        = 1'b0;
   logic       lp_done     = 1'b0;
   logic       lp_err      = 1'b0;
   logic       ts1_rcvd    = 1'b0;
   logic       ts2_rcvd    = 1'b0;
   logic       sbtx;
   logic       lp_req;
   logic       ts_en;
   logic [1:0] ts_type;
   logic       cl0;
   logic       disconnect;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   lane_init_ctrl #(
      .T_CONNECT(T_CONNECT), .T_DISCONNECT(T_DISCONNECT),
      .T_TIMEOUT(T_TIMEOUT), .TS_COUNT(TS_COUNT)
   ) dut (
      .SystemClock(SystemClock), .SystemReset(SystemReset), .enable(enable),
      .sbrx(sbrx), .sbtx(sbtx), .lp_req(lp_req), .lp_done(lp_done),
      .lp_err(lp_err), .ts_en(ts_en), .ts_type(ts_type), .ts1_rcvd(ts1_rcvd),
      .ts2_rcvd(ts2_rcvd), .cl0(cl0), .disconnect(disconnect), .state(state)
   );

   always #5 SystemClock = ~SystemClock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Packed output vector {state, sbtx, lp_req, ts_en, ts_type, cl0, disconnect}.
   function automatic logic [31:0] dutVec();
      return {22'd0, state, sbtx, lp_req, ts_en, ts_type, cl0, disconnect};
   endfunction

   // Behavioural model: lane phase, sbrx run lengths, cycles spent in the phase,
   // and ordered sets counted in the phase.
   int mState, hiRun, loRun, inState, tsSeen, nState;
   bit expLpReq, expDisc, counted;

   always @(posedge SystemClock or negedge SystemReset) begin
      if (!SystemReset) begin
         mState = 0; hiRun = 0; loRun = 0; inState = 0; tsSeen = 0;
         expLpReq = 0; expDisc = 0;
      end else begin
         nState  = mState;
         expDisc = 0;
         counted = (mState == 3 && (ts1_rcvd || ts2_rcvd)) || (mState == 4 && ts2_rcvd);
         if (!enable) nState = 0;
         else if (mState >= 2 && loRun >= T_DISCONNECT) begin
            nState = 1; expDisc = 1;
         end else if (mState >= 2 && mState <= 4 && inState + 1 >= T_TIMEOUT) nState = 1;
         else if (mState == 0) nState = 1;
         else if (mState == 1 && hiRun >= T_CONNECT) nState = 2;
         else if (mState == 2 && lp_err) nState = 1;
         else if (mState == 2 && lp_done) nState = 3;
         else if ((mState == 3 || mState == 4) && counted && tsSeen + 1 >= TS_COUNT)
            nState = mState + 1;
         if (sbrx) begin hiRun++; loRun = 0; end
         else      begin loRun++; hiRun = 0; end
         expLpReq = (nState == 2) && (mState != 2);
         if (nState != mState) begin inState = 0; tsSeen = 0; end
         else begin inState++; if (counted) tsSeen++; end
         mState = nState;
      end
   end

   function automatic logic [31:0] modelVec();
      logic [1:0] t;
      t = (mState == 3) ? 2'd1 : (mState == 4) ? 2'd2 : 2'd0;
      return {22'd0, 3'(mState), mState != 0, expLpReq, (mState == 3 || mState == 4),
              t, mState == 5, expDisc};
   endfunction

   // Every-cycle comparison against the model, away from the active edge.
   bit modelOn = 0;
   always @(negedge SystemClock) begin
      if (modelOn) check("model_outputs", dutVec(), modelVec());
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge SystemClock);
         @(negedge SystemClock);
      end
   endtask

   task automatic pulseTs(input bit t1, input bit t2);
      ts1_rcvd = t1; ts2_rcvd = t2;
      cyc(1);
      ts1_rcvd = 1'b0; ts2_rcvd = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge SystemClock);
      SystemReset = 1'b1;
      modelOn     = 1;
      check("reset_outputs", dutVec(), 32'd0);

      // 1: short sbrx activity never connects.
      enable = 1'b1;
      cyc(1);
      check("enable_detect", 32'(state), 32'd1);
      sbrx = 1'b1; cyc(10);
      sbrx = 1'b0; cyc(10);
      check("short_high_state", 32'(state), 32'd1);
      check("detect_sbtx", 32'(sbtx), 32'd1);

      // 2: full bring-up to CL0.
      sbrx = 1'b1; cyc(25);
      check("connect_not_yet", 32'(state), 32'd1);
      cyc(1);
      check("connect_state", 32'(state), 32'd2);
      check("lp_req_pulse", 32'(lp_req), 32'd1);
      cyc(1);
      check("lp_req_single", 32'(lp_req), 32'd0);
      lp_done = 1'b1; cyc(1); lp_done = 1'b0;
      check("ts1_vec", dutVec(), {22'd0, 3'd3, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0});
      for (int i = 0; i < 15; i++) pulseTs(1, 0);
      check("ts1_15_stays", 32'(state), 32'd3);
      pulseTs(1, 0);
      check("ts1_16_leaves", dutVec(), {22'd0, 3'd4, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0});
      for (int i = 0; i < 16; i++) pulseTs(0, 1);
      check("cl0_vec", dutVec(), {22'd0, 3'd5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0});

      // 3: glitch tolerated, long low disconnects.
      sbrx = 1'b0; cyc(10);
      sbrx = 1'b1; cyc(1);
      check("glitch_cl0", 32'(cl0), 32'd1);
      sbrx = 1'b0; cyc(14);
      check("disc_not_yet", 32'(state), 32'd5);
      cyc(1);
      check("disc_vec", dutVec(), {22'd0, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1});
      cyc(1);
      check("disc_single", 32'(disconnect), 32'd0);
      cyc(4);

      // 4: lane-parameter timeout and retry, then lp_err.
      sbrx = 1'b1; cyc(26);
      check("retry_lp_state", 32'(state), 32'd2);
      cyc(999);
      check("timeout_not_yet", 32'(state), 32'd2);
      cyc(1);
      check("timeout_detect", dutVec(), {22'd0, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0});
      cyc(1);
      check("reenter_lp", 32'(state), 32'd2);
      check("reenter_lp_req", 32'(lp_req), 32'd1);
      lp_err = 1'b1; cyc(1); lp_err = 1'b0;
      check("lp_err_detect", 32'(state), 32'd1);
      cyc(1);

      // 5: mixed TS1/TS2 counting in TRAIN_TS1.
      lp_done = 1'b1; cyc(1); lp_done = 1'b0;
      for (int i = 0; i < 15; i++) pulseTs(i % 2 == 0, i % 2 == 1);
      check("mixed_15_stays", 32'(state), 32'd3);
      pulseTs(0, 1);
      check("mixed_16_ts2", 32'(state), 32'd4);

      // 6: disable drops to DISABLED without a disconnect pulse.
      enable = 1'b0; cyc(1);
      check("disable_vec", dutVec(), 32'd0);
      enable = 1'b1; cyc(2);
      check("reconnect_lp", 32'(state), 32'd2);
      lp_done = 1'b1; lp_err = 1'b1; cyc(1); lp_done = 1'b0; lp_err = 1'b0;
      check("err_wins", 32'(state), 32'd1);
      cyc(1);
      lp_done = 1'b1; cyc(1); lp_done = 1'b0;
      pulseTs(1, 0); pulseTs(1, 0);
      check("pre_reset_ts1", 32'(state), 32'd3);
      #3 SystemReset = 1'b0;
      #1 check("async_reset", dutVec(), 32'd0);
      @(negedge SystemClock);
      SystemReset = 1'b1;

      // Randomized traffic against the model.
      for (int i = 0; i < 30000; i++) begin
         if (sbrx) begin if ($urandom_range(0, 199) == 0) sbrx = 1'b0; end
         else      begin if ($urandom_range(0, 7) == 0)   sbrx = 1'b1; end
         if (enable) begin if ($urandom_range(0, 2999) == 0) enable = 1'b0; end
         else        begin if ($urandom_range(0, 3) == 0)    enable = 1'b1; end
         lp_done  = ($urandom_range(0, 29) == 0);
         lp_err   = ($urandom_range(0, 149) == 0);
         ts1_rcvd = ($urandom_range(0, 2) == 0);
         ts2_rcvd = ($urandom_range(0, 2) == 0);
         cyc(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
